// File: rtl/page_qin_array.sv
// Array of independent per-channel FIFOs with registered producer back-pressure,
// reserve slots and a sticky per-channel overflow flag.
module page_qin_array #(
    parameter int W     = 16,
    parameter int NCH   = 8,
    parameter int DEPTH = 4,
    parameter int RESV  = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH*W-1:0]      qin_d,
    input  logic [NCH-1:0]        qin_e,
    input  logic [NCH-1:0]        qin_v,
    output logic [NCH-1:0]        qin_b,
    output logic [NCH*W-1:0]      qout_d,
    output logic [NCH-1:0]        qout_e,
    output logic [NCH-1:0]        qout_v,
    input  logic [NCH-1:0]        qout_b,
    output logic [NCH*(AW+1)-1:0] occ,
    output logic [NCH-1:0]        ovf,
    input  logic                  clr_ovf
);

    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   BP_LVL   = (AW+1)'(DEPTH - RESV);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W:0]    mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [AW:0]   count;
        logic [AW:0]   count_next;
        logic          full;
        logic          push;
        logic          pop;
        logic          drop;
        logic          back_r;
        logic          ovf_r;

        // A pop frees a slot in the same cycle, so a full queue still accepts a word.
        assign full       = (count == FULL_LVL);
        assign pop        = (count != '0) && !qout_b[i];
        assign push       = qin_v[i] && (!full || pop);
        assign drop       = qin_v[i] && full && !pop;
        assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                back_r <= 1'b0;
                ovf_r  <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                count  <= count_next;
                back_r <= (count_next >= BP_LVL);
                // A fresh overflow wins over a simultaneous clear.
                if (drop) begin
                    ovf_r <= 1'b1;
                end else if (clr_ovf) begin
                    ovf_r <= 1'b0;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (push) begin
                mem[wr_ptr] <= {qin_d[i*W +: W], qin_e[i]};
            end
        end

        assign {qout_d[i*W +: W], qout_e[i]} = mem[rd_ptr];
        assign qout_v[i]                    = (count != '0);
        assign occ[i*(AW+1) +: AW+1]        = count;
        assign qin_b[i]                     = back_r;
        assign ovf[i]                       = ovf_r;
    end

endmodule

// File: tb/tb_page_qin_array.sv
// Randomized bench for page_qin_array: queue-based reference model compared every
// cycle, plus directed sequences with hand-computed expectations.
module tb_page_qin_array;

    localparam int W     = 16;
    localparam int NCH   = 8;
    localparam int DEPTH = 4;
    localparam int RESV  = 1;
    localparam int OW    = 3;

    logic                clock;
    logic                reset;
    logic [NCH*W-1:0]    qin_d;
    logic [NCH-1:0]      qin_e;
    logic [NCH-1:0]      qin_v;
    logic [NCH-1:0]      qin_b;
    logic [NCH*W-1:0]    qout_d;
    logic [NCH-1:0]      qout_e;
    logic [NCH-1:0]      qout_v;
    logic [NCH-1:0]      qout_b;
    logic [NCH*OW-1:0]   occ;
    logic [NCH-1:0]      ovf;
    logic                clr_ovf;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 0;

    logic [W:0] mq [NCH][$];
    bit         m_ovf [NCH];
    bit         m_qinb [NCH];

    page_qin_array #(.W(W), .NCH(NCH), .DEPTH(DEPTH), .RESV(RESV)) dut (
        .clock   (clock),
        .reset   (reset),
        .qin_d   (qin_d),
        .qin_e   (qin_e),
        .qin_v   (qin_v),
        .qin_b   (qin_b),
        .qout_d  (qout_d),
        .qout_e  (qout_e),
        .qout_v  (qout_v),
        .qout_b  (qout_b),
        .occ     (occ),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clock);
        #1;
    endtask

    task automatic pushOne(input int ch, input logic [W-1:0] data, input logic e);
        qin_v               = '0;
        qin_v[ch]           = 1'b1;
        qin_d[ch*W +: W]    = data;
        qin_e[ch]           = e;
        applyStimulus();
        qin_v               = '0;
        qin_e               = '0;
    endtask

    function automatic logic [W-1:0] dataOf(input int ch);
        return qout_d[ch*W +: W];
    endfunction

    function automatic logic [OW-1:0] occOf(input int ch);
        return occ[ch*OW +: OW];
    endfunction

    always @(negedge reset) begin
        for (int ch = 0; ch < NCH; ch++) begin
            mq[ch].delete();
            m_ovf[ch]  = 1'b0;
            m_qinb[ch] = 1'b0;
        end
    end

    // Reference model: each channel is a bounded queue; decisions come from pre-edge state.
    always @(posedge clock) begin
        if (reset) begin
            for (int ch = 0; ch < NCH; ch++) begin
                bit pop_m;
                bit full_m;
                bit drop_m;
                pop_m  = (mq[ch].size() != 0) && !qout_b[ch];
                full_m = (mq[ch].size() == DEPTH);
                drop_m = qin_v[ch] && full_m && !pop_m;
                if (pop_m) void'(mq[ch].pop_front());
                if (qin_v[ch] && !drop_m) mq[ch].push_back({qin_d[ch*W +: W], qin_e[ch]});
                if (drop_m) m_ovf[ch] = 1'b1;
                else if (clr_ovf) m_ovf[ch] = 1'b0;
                m_qinb[ch] = (mq[ch].size() >= DEPTH - RESV);
            end
        end
    end

    always @(negedge clock) begin
        if (run_cmp) begin
            for (int ch = 0; ch < NCH; ch++) begin
                checkOutput($sformatf("cmp_qout_v[%0d]", ch), 64'(qout_v[ch]), 64'(mq[ch].size() != 0));
                checkOutput($sformatf("cmp_occ[%0d]", ch), 64'(occOf(ch)), 64'(mq[ch].size()));
                checkOutput($sformatf("cmp_ovf[%0d]", ch), 64'(ovf[ch]), 64'(m_ovf[ch]));
                checkOutput($sformatf("cmp_qin_b[%0d]", ch), 64'(qin_b[ch]), 64'(m_qinb[ch]));
                if (mq[ch].size() != 0) begin
                    checkOutput($sformatf("cmp_head[%0d]", ch), 64'({dataOf(ch), qout_e[ch]}), 64'(mq[ch][0]));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] exp21 [4];
        int idx;
        int rx;
        int cyc;

        reset   = 1'b1;
        qin_d   = '0;
        qin_e   = '0;
        qin_v   = '0;
        qout_b  = '0;
        clr_ovf = 1'b0;
        #1 reset = 1'b0;
        run_cmp = 1'b1;
        #2;
        checkOutput("reset_qout_v", 64'(qout_v), 64'h0);
        checkOutput("reset_occ", 64'(occ), 64'h0);
        checkOutput("reset_ovf", 64'(ovf), 64'h0);
        checkOutput("reset_qin_b", 64'(qin_b), 64'h0);
        applyStimulus();
        reset = 1'b1;

        // Basic push on ch0, accepted on the first edge after reset release.
        pushOne(0, 16'h1234, 1'b0);
        checkOutput("basic_qout_v", 64'(qout_v), 64'h01);
        checkOutput("basic_data", 64'(dataOf(0)), 64'h1234);
        checkOutput("basic_occ", 64'(occOf(0)), 64'd1);
        applyStimulus();

        // Fill ch3 while the consumer stalls; the fifth word overflows.
        qout_b = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            pushOne(3, 16'hA000 + 16'(k), 1'b0);
            if (k == 0) checkOutput("fill_qin_b_k0", 64'(qin_b[3]), 64'h0);
            if (k == 2) begin
                checkOutput("fill_qin_b_k2", 64'(qin_b[3]), 64'h1);
                checkOutput("fill_occ_k2", 64'(occOf(3)), 64'd3);
            end
            if (k == 3) begin
                checkOutput("fill_occ_k3", 64'(occOf(3)), 64'd4);
                checkOutput("fill_ovf_k3", 64'(ovf), 64'h0);
            end
            if (k == 4) begin
                checkOutput("fill_ovf_k4", 64'(ovf), 64'h08);
                checkOutput("fill_occ_k4", 64'(occOf(3)), 64'd4);
            end
        end
        qout_b[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain3_v", 64'(qout_v[3]), 64'h1);
            checkOutput("drain3_data", 64'(dataOf(3)), 64'hA000 + 64'(k));
            applyStimulus();
        end
        checkOutput("drain3_occ", 64'(occOf(3)), 64'd0);

        // Push and pop together on a full ch5.
        qout_b = 8'hFF;
        for (int k = 0; k < 4; k++) pushOne(5, 16'hB000 + 16'(k), 1'b0);
        qout_b[5] = 1'b0;
        pushOne(5, 16'hBEEF, 1'b0);
        checkOutput("fullpp_occ", 64'(occOf(5)), 64'd4);
        checkOutput("fullpp_ovf", 64'(ovf[5]), 64'h0);
        exp21 = '{16'hB001, 16'hB002, 16'hB003, 16'hBEEF};
        for (int k = 0; k < 4; k++) begin
            checkOutput("fullpp_data", 64'(dataOf(5)), 64'(exp21[k]));
            applyStimulus();
        end

        // End-of-stream bit travels with its own word only.
        qout_b = 8'hFF;
        pushOne(1, 16'hFFFF, 1'b1);
        pushOne(1, 16'h0001, 1'b0);
        checkOutput("eos_e1", 64'(qout_e[1]), 64'h1);
        checkOutput("eos_d1", 64'(dataOf(1)), 64'hFFFF);
        qout_b[1] = 1'b0;
        applyStimulus();
        checkOutput("eos_e0", 64'(qout_e[1]), 64'h0);
        checkOutput("eos_d0", 64'(dataOf(1)), 64'h0001);
        qout_b = '0;
        repeat (5) applyStimulus();

        // Asynchronous reset with three words in every channel.
        checkOutput("pre_reset_ovf", 64'(ovf), 64'h08);
        qout_b = 8'hFF;
        qin_v  = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            qin_d = {4{$urandom()}};
            applyStimulus();
        end
        qin_v = '0;
        checkOutput("occ3_all", 64'(occ), 64'o33333333);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_qout_v", 64'(qout_v), 64'h0);
        checkOutput("async_occ", 64'(occ), 64'h0);
        checkOutput("async_ovf", 64'(ovf), 64'h0);
        checkOutput("async_qin_b", 64'(qin_b), 64'h0);
        applyStimulus();
        reset = 1'b1;
        pushOne(4, 16'h5555, 1'b0);
        checkOutput("post_reset_v", 64'(qout_v), 64'h10);
        checkOutput("post_reset_d", 64'(dataOf(4)), 64'h5555);
        qout_b = '0;
        repeat (2) applyStimulus();

        // Overflow clear, and overflow beating a simultaneous clear.
        qout_b = 8'hFF;
        for (int k = 0; k < 5; k++) pushOne(2, 16'hC000 + 16'(k), 1'b0);
        checkOutput("ovf2_set", 64'(ovf), 64'h04);
        clr_ovf = 1'b1;
        applyStimulus();
        checkOutput("ovf2_clr", 64'(ovf), 64'h0);
        pushOne(2, 16'hC0FF, 1'b0);
        checkOutput("ovf2_clr_and_set", 64'(ovf), 64'h04);
        applyStimulus();
        clr_ovf = 1'b0;
        checkOutput("ovf2_clr_again", 64'(ovf), 64'h0);
        qout_b = '0;
        repeat (5) applyStimulus();

        // Ten sequential words on ch7 with a random consumer, producer honouring qin_b.
        idx = 0;
        rx  = 0;
        cyc = 0;
        while (rx < 10 && cyc < 400) begin
            qout_b[7] = 1'($urandom_range(0, 1));
            qin_v[7]  = 1'b0;
            if (idx < 10 && !qin_b[7]) begin
                qin_v[7]       = 1'b1;
                qin_d[7*W +: W] = 16'(idx);
                idx++;
            end
            if (qout_v[7] && !qout_b[7]) begin
                checkOutput("wrap_order", 64'(dataOf(7)), 64'(rx));
                rx++;
            end
            applyStimulus();
            cyc++;
        end
        qin_v = '0;
        checkOutput("wrap_count", 64'(rx), 64'd10);
        checkOutput("wrap_ovf", 64'(ovf[7]), 64'h0);
        qout_b = '0;
        repeat (5) applyStimulus();

        // Fully random traffic on all channels with occasional clears and reset pulses.
        for (int c = 0; c < 3000; c++) begin
            qin_v   = 8'($urandom());
            qin_d   = {$urandom(), $urandom(), $urandom(), $urandom()};
            qin_e   = 8'($urandom());
            qout_b  = (c % 600 < 300) ? 8'($urandom() & $urandom()) : 8'($urandom() | $urandom());
            clr_ovf = ($urandom_range(0, 15) == 0);
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
            applyStimulus();
        end
        reset   = 1'b1;
        qin_v   = '0;
        clr_ovf = 1'b0;
        applyStimulus();
        run_cmp = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
